dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port 256x8 data memory (with memory-mapped I/O at 0xFF) between the processor datapath (port 0) and a second requester such as a program loader or debug port (port 1). It sits between the requesters and the data memory's mem_read/mem_write/address/write_data/read_data port. It grants at most one transfer per cycle using round-robin priority, with an optional bounded bus lock for back-to-back accesses. Read data returns one cycle after the grant.

## Interface
- AW, 8, address width
- DW, 8, data width
- MAX_LOCK, 8, maximum consecutive cycles one port may hold a lock (≥2)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- reqN  in  1  port N (N=0,1) requests a transfer this cycle
- weN  in  1  1 = write, 0 = read
- addrN  in  AW  port N address
- wdataN  in  DW  port N write data
- lockN  in  1  hold the bus after this grant (present only with DMEM_ARB_LOCK_EN)
- gntN  out  1  transfer accepted this cycle (combinational)
- rvalidN  out  1  rdataN valid (registered, one cycle after a read grant)
- rdataN  out  DW  read data for port N
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_read

## Operation
- A transfer completes at the rising edge of any cycle in which gntN=1. There is no stall: a requester whose gnt=0 holds its request.
- Memory drive, combinational from the granted port g:
  - mem_read = gnt_g & ~we_g
  - mem_write = gnt_g & we_g
  - mem_addr = addr_g and mem_wdata = wdata_g; both are 0 when there is no grant.
- Address 0xFF is passed through unchanged. Its I/O semantics are handled by the memory.
- Round-robin state: a `last` register holds the most recently granted port. Reset value is 1, so port 0 wins the first tie.
- FSM states are OPEN, LOCK0 and LOCK1.
  - OPEN, one requester: that requester is granted.
  - OPEN, both requesting: the port that is not `last` is granted. `last` updates on every grant.
  - OPEN → LOCKk: at the edge where port k is granted with lockk=1. lock_cnt is cleared to 0 on entry.
  - LOCKk: only port k can be granted (gntk = reqk), and the other port's gnt is 0. lock_cnt increments every cycle.
  - LOCKk → OPEN: at the edge where lockk=0, or where lock_cnt == MAX_LOCK-1. On the timeout exit, `last` is forced to k, so the other port wins the next tie.
- Read return:
  - rvalidN is registered as gntN & ~weN.
  - rdataN = mem_rdata when rvalidN=1, otherwise 0.
- Reset values:
  - State OPEN, last=1, lock_cnt=0.
  - rvalid0 = rvalid1 = 0, so rdata0 = rdata1 = 0.
  - While reset is high, gnt0, gnt1, mem_read and mem_write are all forced to 0.
- Reset asserted mid-lock or with a read in flight: state returns to OPEN immediately and pending rvalid is cleared. The in-flight read data is discarded.

## Timing
- Grant latency: 0 cycles (same cycle as the request) when the port wins arbitration.
- Read latency: grant at edge t, then rvalid/rdata are valid during cycle t+1.
- Write takes effect at the grant edge. A read of the same address granted in the next cycle returns the new value.
- Back-to-back reads alternate between ports under contention. Each port can sustain 1 transfer per 2 cycles while both request continuously, and 1 per cycle alone.
- Worst-case wait for a port under contention: 1 cycle without lock. With lock it is MAX_LOCK+1 cycles.

## Configuration
- DMEM_ARB_LOCK_EN defined:
  - lock0/lock1 ports exist.
  - LOCK0/LOCK1 states and lock_cnt are implemented as above.
- DMEM_ARB_LOCK_EN undefined:
  - lock ports are absent.
  - The FSM is permanently OPEN and arbitration is pure round-robin.
  - lock_cnt is not instantiated.

## Test plan
- Reset release, only req0 reads addr 0x10 (RAM preloaded with 0x5A): gnt0=1 in the same cycle; next cycle rvalid0=1 and rdata0=0x5A; all port-1 outputs stay 0.
- req0 and req1 both held high for 4 cycles: grant order is 0,1,0,1, and mem_addr alternates addr0/addr1.
- Port 1 writes 0x33 to 0x20 at edge t, then port 0 reads 0x20 at t+1: rdata0=0x33 at t+2.
- With DMEM_ARB_LOCK_EN and MAX_LOCK=4, port 1 holds lock1=1 with continuous req1 while req0 is high:
  - gnt1 is held for 5 consecutive cycles (the entry grant plus 4 LOCK1 cycles) and gnt0 is held low.
  - Port 0 is granted on the cycle after the timeout exit.
- Assert reset while in LOCK0 with a read in flight: rvalid0 goes to 0 immediately. After release, a port-1 request is granted at once.

Source files
------------

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-port round-robin arbiter in front of the single-port
//             256x8 data memory. Port 0 is the datapath and port 1 is a
//             loader/debug requester. Grants are combinational and read
//             data returns one cycle after the grant. When the macro
//             DMEM_ARB_LOCK_EN is defined, a port can hold the bus for a
//             bounded number of cycles (MAX_LOCK).
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Most recently granted port; 1 at reset so port 0 wins the first tie.
  logic last_q, last_d;
  logic rvalid0_q, rvalid0_d;
  logic rvalid1_q, rvalid1_d;

  // Plain round-robin decision, used whenever the bus is not locked.
  logic rr_gnt0, rr_gnt1;
  assign rr_gnt0 = req0 & (~req1 | last_q);
  assign rr_gnt1 = req1 & (~req0 | ~last_q);

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {
    OPEN  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam int            CW       = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOCK - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  // Grant selection: the lock owner is the only candidate while locked.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state_q)
        LOCK0:   gnt0 = req0;
        LOCK1:   gnt1 = req1;
        default: begin
          gnt0 = rr_gnt0;
          gnt1 = rr_gnt1;
        end
      endcase
    end
  end

  // Next round-robin pointer, lock state and lock cycle counter.
  always_comb begin
    last_d     = last_q;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
    case (state_q)
      OPEN: begin
        if (gnt0 && lock0) begin
          state_d    = LOCK0;
          lock_cnt_d = '0;
        end else if (gnt1 && lock1) begin
          state_d    = LOCK1;
          lock_cnt_d = '0;
        end
      end
      LOCK0: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        // Timeout hands the next tie to the other port.
        if (lock_cnt_q == CNT_LAST) begin
          state_d = OPEN;
          last_d  = 1'b0;
        end else if (!lock0) begin
          state_d = OPEN;
        end
      end
      LOCK1: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (lock_cnt_q == CNT_LAST) begin
          state_d = OPEN;
          last_d  = 1'b1;
        end else if (!lock1) begin
          state_d = OPEN;
        end
      end
      default: state_d = OPEN;
    endcase
  end

  // Lock FSM registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= OPEN;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  // Without bus locking the parameter has no effect.
  logic [31:0] unused_max_lock;
  assign unused_max_lock = 32'(MAX_LOCK);

  // Grant selection: pure round-robin, suppressed while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      gnt0 = rr_gnt0;
      gnt1 = rr_gnt1;
    end
  end

  // Next round-robin pointer follows every grant.
  always_comb begin
    last_d = last_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
  end
`endif

  // Read-return valid for each port, one cycle after a read grant.
  always_comb begin
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
  end

  // Arbitration pointer and read-valid registers; reset drops in-flight reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // Memory port driven from the granted requester, idle values otherwise.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_read  = ~we0;
      mem_write = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_read  = ~we1;
      mem_write = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rvalid0_q ? mem_rdata : '0;
  assign rdata1  = rvalid1_q ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter with a behavioural 256x8
//             RAM behind it. Expected read data is queued when a read grant
//             is seen and compared when the read returns.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MAX_LOCK = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
`ifdef DMEM_ARB_LOCK_EN
  logic          lock0 = 1'b0, lock1 = 1'b0;
`endif
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
`ifdef DMEM_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: write at the edge, read data one cycle later.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_rdata = '0;
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    if (mem_read)  ram_rdata <= ram[mem_addr];
  end
  assign mem_rdata = ram_rdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [DW-1:0] data; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  logic [DW-1:0] shadow [256];

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: each cycle, rvalid/rdata must match the queue head due now.
  exp_t          m_e;
  logic          m_v;
  logic [DW-1:0] m_d;
  always @(negedge clk) begin
    if (!reset) begin
      m_v = 1'b0; m_d = '0;
      if (q0.size() > 0 && q0[0].cyc == cyc) begin
        m_e = q0.pop_front(); m_v = 1'b1; m_d = m_e.data;
      end
      n_checks++;
      if (rvalid0 !== m_v) begin
        n_fail++; $display("FAIL rvalid0 @cyc %0d: got %b expected %b", cyc, rvalid0, m_v);
      end
      n_checks++;
      if (rdata0 !== m_d) begin
        n_fail++; $display("FAIL rdata0 @cyc %0d: got %h expected %h", cyc, rdata0, m_d);
      end
      m_v = 1'b0; m_d = '0;
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
        m_e = q1.pop_front(); m_v = 1'b1; m_d = m_e.data;
      end
      n_checks++;
      if (rvalid1 !== m_v) begin
        n_fail++; $display("FAIL rvalid1 @cyc %0d: got %b expected %b", cyc, rvalid1, m_v);
      end
      n_checks++;
      if (rdata1 !== m_d) begin
        n_fail++; $display("FAIL rdata1 @cyc %0d: got %h expected %h", cyc, rdata1, m_d);
      end
    end
  end

  task automatic set0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    set0(0, 0, '0, '0); set1(0, 0, '0, '0);
`ifdef DMEM_ARB_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif
    reset = 1'b1;
    q0.delete(); q1.delete();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    set0(1, 0, 8'h10, '0); set1(1, 1, 8'h20, 8'h77);
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_gnt: got %b%b expected 00", gnt0, gnt1);
    end
    n_checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_en: got rd=%b wr=%b expected 0 0", mem_read, mem_write);
    end
    n_checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== '0 || rdata1 !== '0) begin
      n_fail++; $display("FAIL reset_rvalid: got %b %b %h %h expected 0 0 00 00", rvalid0, rvalid1, rdata0, rdata1);
    end
    do_reset();
  endtask

  task automatic test_single_read;
    set0(1, 1, 8'h10, 8'h5A);
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b1 || mem_write !== 1'b1 || mem_wdata !== 8'h5A) begin
      n_fail++; $display("FAIL preload_write: got gnt0=%b wr=%b wdata=%h expected 1 1 5a", gnt0, mem_write, mem_wdata);
    end
    shadow[8'h10] = 8'h5A;
    tick();
    do_reset();
    set0(1, 0, 8'h10, '0);
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL single_read_gnt: got %b%b expected 10", gnt0, gnt1);
    end
    n_checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 8'h10) begin
      n_fail++; $display("FAIL single_read_mem: got rd=%b wr=%b addr=%h expected 1 0 10", mem_read, mem_write, mem_addr);
    end
    q0.push_back('{cyc + 1, 8'h5A});
    tick();
    set0(0, 0, '0, '0);
    tick();
  endtask

  task automatic test_write_read;
    set1(1, 1, 8'h20, 8'h33);
    @(negedge clk);
    n_checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      n_fail++; $display("FAIL write1_gnt: got %b%b expected 01", gnt0, gnt1);
    end
    n_checks++;
    if (mem_write !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'h33) begin
      n_fail++; $display("FAIL write1_mem: got wr=%b addr=%h wdata=%h expected 1 20 33", mem_write, mem_addr, mem_wdata);
    end
    shadow[8'h20] = 8'h33;
    tick();
    set1(0, 0, '0, '0); set0(1, 0, 8'h20, '0);
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 8'h20) begin
      n_fail++; $display("FAIL read_after_write: got gnt0=%b rd=%b addr=%h expected 1 1 20", gnt0, mem_read, mem_addr);
    end
    q0.push_back('{cyc + 1, 8'h33});
    tick();
    set0(0, 0, '0, '0);
    tick();
  endtask

  task automatic test_contention;
    int exp_p;
    do_reset();
    set0(1, 0, 8'h10, '0); set1(1, 0, 8'h20, '0);
    exp_p = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (gnt0 !== (exp_p == 0) || gnt1 !== (exp_p == 1)) begin
        n_fail++; $display("FAIL contention_gnt[%0d]: got %b%b expected port %0d", i, gnt0, gnt1, exp_p);
      end
      n_checks++;
      if (mem_addr !== ((exp_p == 0) ? 8'h10 : 8'h20)) begin
        n_fail++; $display("FAIL contention_addr[%0d]: got %h expected %h", i, mem_addr, (exp_p == 0) ? 8'h10 : 8'h20);
      end
      if (exp_p == 0) q0.push_back('{cyc + 1, shadow[8'h10]});
      else            q1.push_back('{cyc + 1, shadow[8'h20]});
      tick();
      exp_p = 1 - exp_p;
    end
    set0(0, 0, '0, '0); set1(0, 0, '0, '0);
    tick();
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] seq [3];
    seq[0] = 8'h10; seq[1] = 8'h20; seq[2] = 8'h10;
    for (int i = 0; i < 3; i++) begin
      set1(1, 0, seq[i], '0);
      @(negedge clk);
      n_checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_addr !== seq[i]) begin
        n_fail++; $display("FAIL b2b_alone[%0d]: got gnt=%b%b addr=%h expected 01 %h", i, gnt0, gnt1, mem_addr, seq[i]);
      end
      q1.push_back('{cyc + 1, shadow[seq[i]]});
      tick();
    end
    set1(0, 0, '0, '0);
    tick();
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock_timeout;
    do_reset();
    set0(1, 0, 8'h10, '0);
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b1) begin
      n_fail++; $display("FAIL lock_setup_gnt0: got %b expected 1", gnt0);
    end
    q0.push_back('{cyc + 1, shadow[8'h10]});
    tick();
    set1(1, 0, 8'h20, '0); lock1 = 1'b1;
    for (int i = 0; i < MAX_LOCK + 1; i++) begin
      @(negedge clk);
      n_checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
        n_fail++; $display("FAIL lock1_hold[%0d]: got %b%b expected 01", i, gnt0, gnt1);
      end
      q1.push_back('{cyc + 1, shadow[8'h20]});
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL lock1_timeout_release: got %b%b expected 10", gnt0, gnt1);
    end
    q0.push_back('{cyc + 1, shadow[8'h10]});
    tick();
    set0(0, 0, '0, '0); set1(0, 0, '0, '0); lock1 = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_inflight;
    do_reset();
    set0(1, 0, 8'h10, '0);
`ifdef DMEM_ARB_LOCK_EN
    lock0 = 1'b1;
`endif
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b1) begin
      n_fail++; $display("FAIL inflight_first_gnt0: got %b expected 1", gnt0);
    end
    q0.push_back('{cyc + 1, shadow[8'h10]});
    tick();
    set0(1, 0, 8'h20, '0);
`ifdef DMEM_ARB_LOCK_EN
    set1(1, 0, 8'h10, '0);
`endif
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL inflight_second_gnt: got %b%b expected 10", gnt0, gnt1);
    end
    tick();
    n_checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== shadow[8'h20]) begin
      n_fail++; $display("FAIL inflight_before_reset: got %b %h expected 1 %h", rvalid0, rdata0, shadow[8'h20]);
    end
    reset = 1'b1;
    #1;
    q0.delete();
    n_checks++;
    if (rvalid0 !== 1'b0 || rdata0 !== '0) begin
      n_fail++; $display("FAIL inflight_reset_drop: got %b %h expected 0 00", rvalid0, rdata0);
    end
    n_checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_read !== 1'b0) begin
      n_fail++; $display("FAIL inflight_reset_gnt: got %b%b rd=%b expected 00 0", gnt0, gnt1, mem_read);
    end
    set0(0, 0, '0, '0);
`ifdef DMEM_ARB_LOCK_EN
    lock0 = 1'b0;
`endif
    set1(1, 0, 8'h20, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_gnt1: got %b%b expected 01", gnt0, gnt1);
    end
    q1.push_back('{cyc + 1, shadow[8'h20]});
    tick();
    set1(0, 0, '0, '0);
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_back_to_back();
`ifdef DMEM_ARB_LOCK_EN
    test_lock_timeout();
`endif
    test_reset_inflight();
    tick();
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d/%0d pending reads expected 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
